// File: rtl/proc_mem.sv
// Processor instruction/data memory with a word-serial valid/ready program loader.
// Define PROC_MEM_CLEAR_EN to zero the whole array after every reset before loading.
module proc_mem #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_rw,
    output logic [DATA_W-1:0] m_q,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              ld_start,
    output logic              exec,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_ovf
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

`ifdef PROC_MEM_CLEAR_EN
    typedef enum logic [1:0] {StClear, StIdle, StLoad, StRun} state_e;
    localparam state_e RESET_STATE = StClear;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
    localparam state_e RESET_STATE = StIdle;
`endif

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              last_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign accept    = ld_valid && ld_ready && (state_q == StIdle || state_q == StLoad);
    // The top address always ends a load; the pointer never wraps.
    assign last_word = ld_last || (ptr_q == TOP_ADDR);

    // Single write port shared by the clear sweep, the loader and processor stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = m_addr;
        mem_wdata = m_data;
        case (state_q)
`ifdef PROC_MEM_CLEAR_EN
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
            end
`endif
            StIdle, StLoad: begin
                mem_we    = accept;
                mem_waddr = ptr_q;
                mem_wdata = ld_data;
            end
            StRun:   mem_we = m_rw;
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= RESET_STATE;
            ptr_q    <= '0;
            ld_count <= '0;
            ld_ovf   <= 1'b0;
            m_q      <= '0;
            exec     <= 1'b0;
            ld_ready <= 1'b0;
        end else begin
            m_q <= '0;
            case (state_q)
`ifdef PROC_MEM_CLEAR_EN
                StClear: begin
                    // Pointer doubles as the sweep address and wraps back to 0 for IDLE.
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == TOP_ADDR) begin
                        state_q <= StIdle;
                    end
                end
`endif
                StIdle, StLoad: begin
                    ld_ready <= 1'b1;
                    if (accept) begin
                        ld_count <= ld_count + 1'b1;
                        if (ptr_q != TOP_ADDR) begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                        if (last_word) begin
                            state_q  <= StRun;
                            ld_ready <= 1'b0;
                            exec     <= 1'b1;
                            ld_ovf   <= !ld_last;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StRun: begin
                    // Non-blocking read gives the old word on a same-address store.
                    m_q <= mem[m_addr];
                    if (ld_start) begin
                        state_q  <= StIdle;
                        exec     <= 1'b0;
                        ld_ready <= 1'b1;
                        ptr_q    <= '0;
                        ld_count <= '0;
                        ld_ovf   <= 1'b0;
                    end
                end
                default: state_q <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_mem.sv
// Self-checking bench for proc_mem: directed sequence with random data against a memory model.
module tb_proc_mem;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_rw = 1'b0;
    logic [DATA_W-1:0] m_q;
    logic              ld_valid = 1'b0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              ld_last = 1'b0;
    logic              ld_ready;
    logic              ld_start = 1'b0;
    logic              exec;
    logic [ADDR_W:0]   ld_count;
    logic              ld_ovf;

    proc_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_rw     (m_rw),
        .m_q      (m_q),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_start (ld_start),
        .exec     (exec),
        .ld_count (ld_count),
        .ld_ovf   (ld_ovf)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference memory: only addresses with a known value are present.
    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] words [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic read_check(input int addr, input string tag);
        m_addr = addr[ADDR_W-1:0];
        m_rw   = 1'b0;
        step();
        if (ref_mem.exists(addr)) check(tag, m_q, ref_mem[addr]);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
`ifdef PROC_MEM_CLEAR_EN
        begin
            bit seen = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                step();
                if (ld_ready) seen = 1'b1;
            end
            check("clear_ready_low", seen, 1'b0);
            for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        end
`else
        check("ready_pre", ld_ready, 1'b0);
`endif
        step();
        check("ready_up", ld_ready, 1'b1);
    endtask

    task automatic do_reset();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
        m_rw     = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_mq", m_q, 0);
        check("rst_exec", exec, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_count", ld_count, 0);
        check("rst_ovf", ld_ovf, 0);
        release_reset();
    endtask

    // Load the words queue from address 0; toggle inserts an idle cycle before each word.
    task automatic load(input bit with_last, input bit toggle);
        int n = words.size();
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                ld_valid = 1'b0;
                ld_data  = DATA_W'($urandom);
                ld_last  = 1'($urandom);
                step();
                check("gap_count", ld_count, i);
            end
            ld_valid = 1'b1;
            ld_data  = words[i];
            ld_last  = with_last && (i == n - 1);
            step();
            ref_mem[i] = words[i];
            if (n <= 16 || i >= n - 2) begin
                check("ld_count", ld_count, i + 1);
                check("ld_exec", exec, (i == n - 1) ? 1 : 0);
                check("ld_mq_zero", m_q, 0);
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("ld_ready_run", ld_ready, 0);
        check("ld_ovf", ld_ovf, with_last ? 0 : 1);
    endtask

    task automatic pulse_start();
        m_rw     = 1'b0;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        check("start_exec", exec, 0);
        check("start_ready", ld_ready, 1);
        check("start_count", ld_count, 0);
        check("start_ovf", ld_ovf, 0);
    endtask

    initial begin
        // Reset and the three-word program.
        do_reset();
        words = '{16'h8001, 16'h8102, 16'hC0D0};
        load(1'b1, 1'b0);
        for (int a = 0; a < 3; a++) read_check(a, "prog_read");

        // Read-during-write on the same address returns the old word.
        begin
            logic [DATA_W-1:0] v = DATA_W'($urandom);
            m_addr = 12'h050; m_data = v; m_rw = 1'b1;
            step();
            ref_mem[12'h050] = v;
            m_data = 16'h1234;
            step();
            check("rdw_old", m_q, v);
            ref_mem[12'h050] = 16'h1234;
            read_check(12'h050, "rdw_new");
        end

        // Random processor traffic over a small window to force address reuse.
        for (int i = 0; i < 200; i++) begin
            int a = $urandom_range(0, 63);
            logic [DATA_W-1:0] d = DATA_W'($urandom);
            logic w = 1'($urandom);
            m_addr = a[ADDR_W-1:0]; m_data = d; m_rw = w;
            step();
            if (ref_mem.exists(a)) check("rand_rd", m_q, ref_mem[a]);
            if (w) ref_mem[a] = d;
        end

        // Abandon RUN; stores and reads are ignored outside RUN.
        pulse_start();
        m_addr = 12'h050; m_data = 16'hDEAD; m_rw = 1'b1;
        step();
        check("idle_mq", m_q, 0);
        check("idle_exec", exec, 0);
        m_rw = 1'b0;

        // Five-word load with ld_valid toggling.
        words = {};
        for (int i = 0; i < 5; i++) words.push_back(DATA_W'($urandom));
        load(1'b1, 1'b1);
        for (int a = 0; a < 6; a++) read_check(a, "tog_read");
        read_check(12'h050, "ignored_store");

        // Single-word reload keeps everything above address 0.
        pulse_start();
        words = '{16'h5A5A};
        load(1'b1, 1'b0);
        for (int a = 0; a < 5; a++) read_check(a, "reload_read");
        read_check(12'h050, "reload_keep");

        // Full-depth load without ld_last overflows into RUN.
        pulse_start();
        words = {};
        for (int i = 0; i < DEPTH; i++) words.push_back(DATA_W'($urandom));
        load(1'b0, 1'b0);
        check("ovf_count", ld_count, DEPTH);
        read_check(0, "ovf_addr0");
        read_check(DEPTH - 1, "ovf_top");
        for (int i = 0; i < 8; i++) read_check($urandom_range(0, DEPTH - 1), "ovf_rand");

        // ld_valid in RUN is ignored.
        ld_valid = 1'b1;
        ld_data  = 16'hFFFF;
        repeat (3) step();
        ld_valid = 1'b0;
        check("run_valid_count", ld_count, DEPTH);
        check("run_valid_exec", exec, 1);

        // Reset in the middle of a load; contents survive unless cleared.
        pulse_start();
        ld_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ld_data = DATA_W'($urandom);
            step();
            ref_mem[i] = ld_data;
        end
        ld_valid = 1'b0;
        check("midload_exec", exec, 0);
        do_reset();
        words = '{16'h0F0F};
        load(1'b1, 1'b0);
        read_check(0, "post_rst_addr0");
        read_check(1, "post_rst_addr1");
        read_check(4000, "post_rst_addr4000");

`ifdef PROC_MEM_CLEAR_EN
        // Reset part way through the sweep restarts it from address 0.
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (100) step();
        check("sweep_ready", ld_ready, 0);
        do_reset();
        words = '{16'hBEEF};
        load(1'b1, 1'b0);
        for (int a = 0; a < 8; a++) read_check(a, "clear_read");
        for (int i = 0; i < 8; i++) read_check($urandom_range(1, DEPTH - 1), "clear_rand");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/proc_mem.md
# proc_mem

Single-port instruction/data memory that answers the pipelined processor's memory interface (`m_addr`, `m_data`, `m_rw`, `m_q`). It also contains a word-serial program loader with a valid/ready handshake. The block holds the processor idle (`exec` low) until a program has been loaded, then serves fetch, load and store traffic. It sits between the processor core and the board-level program source.

## Interface
Parameters:
- `ADDR_W`, 12, address width; memory depth is 2^ADDR_W words
- `DATA_W`, 16, word width

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `m_addr`  in  ADDR_W  processor word address
- `m_data`  in  DATA_W  processor store data
- `m_rw`  in  1  1 = write `m_data` to `m_addr`, 0 = read
- `m_q`  out  DATA_W  registered read data to processor
- `ld_valid`  in  1  loader word present
- `ld_data`  in  DATA_W  loader word
- `ld_last`  in  1  qualifies the final loader word
- `ld_ready`  out  1  block can accept a loader word
- `ld_start`  in  1  single-cycle pulse; abandons RUN and restarts loading
- `exec`  out  1  program loaded; processor may run
- `ld_count`  out  ADDR_W+1  number of words accepted in the current load
- `ld_ovf`  out  1  sticky flag; load hit the top address without `ld_last`

## Operation
- FSM states: CLEAR (only with macro), IDLE, LOAD, RUN. Reset value: CLEAR if the macro is defined, otherwise IDLE.
- IDLE: `ld_ready`=1, `exec`=0, load pointer=0. An accepted word (`ld_valid`&`ld_ready` at a rising edge) writes `mem[0]` and moves the FSM to LOAD. If that word carries `ld_last`, the FSM goes directly to RUN.
- LOAD: `ld_ready`=1. Each accepted word writes `mem[ptr]`, then `ptr++` and `ld_count++`.
  - Accepted word with `ld_last`: go to RUN.
  - Accepted word at address 2^ADDR_W-1 without `ld_last`: set `ld_ovf`, treat the word as last, go to RUN. The pointer never wraps.
- RUN: `ld_ready`=0, `exec`=1.
  - `m_rw`=1 writes `mem[m_addr]`=`m_data` at the edge.
  - Every edge registers `m_q`=`mem[m_addr]`. Same-address read-during-write returns the OLD word.
- `ld_start` in RUN: go to IDLE, clear pointer, `ld_count` and `ld_ovf`. Memory contents are kept. `ld_start` in any other state is ignored.
- Outside RUN: `m_rw` is ignored (no write) and `m_q` registers 0.
- `ld_valid` in RUN is ignored. `ld_data` is don't-care when `ld_valid`=0.
- Reset asserted mid-operation:
  - FSM returns to its reset state, pointer=0, `ld_count`=0, `ld_ovf`=0, `m_q`=0, `exec`=0, `ld_ready`=0.
  - Memory array is not reset, except by CLEAR.

## Timing
- Reset values: `m_q`=0, `exec`=0, `ld_ready`=0, `ld_count`=0, `ld_ovf`=0.
- `ld_ready` rises one cycle after reset release (no macro), or one cycle after CLEAR ends (with macro).
- Read latency: 1 cycle. `m_addr` is sampled at edge N and `m_q` is valid after edge N.
- Store latency: a store at edge N is visible to a read sampled at edge N+1.
- Loader throughput: one word per cycle while `ld_valid` stays high.
- `exec` rises at the edge that accepts the last word. The first valid fetch data follows one edge later.
- `exec` falls at the edge that samples `ld_start`. `m_q` reads 0 from the next edge.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- `PROC_MEM_CLEAR_EN` defined:
  - After reset release the FSM is in CLEAR and writes 0 to one address per cycle, from 0 to 2^ADDR_W-1.
  - CLEAR lasts 2^ADDR_W cycles with `ld_ready`=0, then the FSM enters IDLE.
  - Reset during CLEAR restarts the sweep at address 0.
- Undefined: no CLEAR state. Reset goes straight to IDLE, and contents are undefined at power-up and retained across reset.

## Test plan
- Reset, then load 3 words (16'h8001, 16'h8102, 16'hC0D0, last on the third) -> `ld_count`=3, `exec` rises on the 3rd accept edge, and reads of addresses 0..2 return those words one cycle later.
- In RUN, store 16'h1234 to address 12'h050 and read 12'h050 on the same edge -> old value returned; the read on the next edge returns 16'h1234.
- Toggle `ld_valid` every other cycle during a load -> only handshaken words are written, and `ld_count` matches the number of accepts.
- Load 4096 words with no `ld_last` -> `ld_ovf`=1, `exec`=1, `ld_count`=4096, and address 0 holds the first word.
- In RUN, pulse `ld_start` -> `exec`=0 and `m_q`=0 on following edges; reload 1 word -> `exec`=1 and earlier contents above address 0 are intact.
- With `PROC_MEM_CLEAR_EN`: assert reset at sweep address 100 -> after release, `ld_ready` stays 0 for 4096 cycles, and all reads return 0 after loading a single word at address 0.
